gmii_tx_arbiter: RTL and testbench
==================================

// Module: gmii_tx_arbiter
// PURPOSE
//  Shares the single GMII transmit path (gmii_en/gmii_dout into the hub) between NPORT
//  frame-buffer FIFOs. Grants whole frames round-robin, generates preamble/SFD, streams
//  the frame, enforces the inter-frame gap and flags underrun/oversize with gmii_er.
//  Sits between the per-port frame FIFOs and the hub GMII TX input.
// PARAMETERS
//  NPORT       4     number of requesting frame FIFOs (2..8)
//  N_PREAMBLE  8     preamble length in bytes incl. SFD (last byte 0xD5, others 0x55)
//  N_IFG       12    idle cycles (gmii_en=0) between frames, exact when back-to-back
//  MAX_FRAME   1522  maximum frame bytes, excluding preamble
// PORTS
//  clk_125m      in   1        GMII TX clock, all logic on posedge
//  rst_n         in   1        synchronous, active-low reset
//  frame_ready   in   NPORT    port i holds >=1 complete frame
//  rd_empty      in   NPORT    port i FIFO empty (FWFT)
//  rd_data       in   NPORT*8  port i head byte, bits [8i+7:8i], valid when !rd_empty[i]
//  rd_last       in   NPORT    head byte of port i is last byte of its frame
//  rd_en         out  NPORT    pop port i head byte (combinational, one-hot or 0)
//  grant         out  NPORT    one-hot owner of current frame, 0 when idle
//  gmii_en       out  1        GMII TX enable (registered)
//  gmii_dout     out  8        GMII TX data (registered)
//  gmii_er       out  1        GMII TX error (registered)
//  err_cnt       out  16       saturating count of underrun + oversize events
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rd_en=0, gmii_en=0, gmii_dout=0, gmii_er=0, err_cnt=0,
//   RR pointer=NPORT-1 (port 0 wins first). Reset mid-frame aborts immediately; FIFO
//   contents are left untouched (FIFO owner flushes).
//  States: IDLE, PRE, DATA, DROP, IFG.
//  IDLE: gmii_en=0. On an edge with any frame_ready: grant = first ready port after RR
//   pointer (wrapping), pointer<=granted port, ->PRE. gmii_en rises on the following edge.
//  PRE: N_PREAMBLE cycles registering gmii_en=1, dout 0x55..0x55,0xD5; ->DATA on SFD edge.
//  DATA: rd_en[g]=!rd_empty[g]. Each edge: gmii_en<=1, gmii_dout<=rd_data[g], byte_cnt++.
//   Popped byte with rd_last -> IFG. Preamble and data are contiguous, no bubbles.
//  Underrun (rd_empty[g]=1 in DATA): no pop, register gmii_en=1, gmii_er=1, dout=0x00 for
//   one cycle, err_cnt++, ->DROP.
//  Oversize: popping byte MAX_FRAME+1 without rd_last: that byte not sent; register er
//   cycle as for underrun, err_cnt++, ->DROP.
//  DROP: gmii_en=0; pop port g whenever !rd_empty until the rd_last byte is popped -> IFG.
//  IFG: exactly N_IFG edges register gmii_en=0; on the N_IFG-th edge arbitrate as in IDLE
//   (-> PRE if any frame_ready, else IDLE). Back-to-back frames therefore see exactly N_IFG
//   idle cycles.
//  gmii_er=0 except the single error cycle. err_cnt saturates at 0xFFFF. grant is held
//   from arbitration through the end of IFG; it is 0 only in IDLE.
//  frame_ready changes during a frame never affect the current owner. Simultaneous
//   requests resolve strictly RR.
// TESTING
//  1 Port0 60-byte frame after reset -> 7x0x55, 0xD5, 60 data bytes in order, gmii_en=0
//    afterwards, rd_en pulses exactly 60.
//  2 Ports 0..3 each ready with 2 frames -> order 0,1,2,3,0,1,2,3; exactly 12 idle cycles
//    between frames.
//  3 Port2 rd_empty forced high at byte 20 of 64 for 5 cycles -> one gmii_er cycle after
//    byte 19, remaining 44 bytes drained with gmii_en=0, err_cnt=1, next frame clean.
//  4 Port1 1600 bytes, no rd_last before byte 1600 -> 1522 bytes sent, er on the next
//    cycle, rest dropped, err_cnt=1.
//  5 rst_n low for 1 cycle mid-DATA -> next edge gmii_en=0, grant=0, err_cnt=0; port 0
//    wins next.
//  6 Only port3 ready repeatedly -> port3 re-granted each time, gap exactly N_IFG.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// Round-robin frame arbiter for the shared GMII TX path: grants whole frames, prepends the
// preamble/SFD, enforces the inter-frame gap and marks underrun/oversize frames with gmii_er.
module gmii_tx_arbiter #(
    parameter int unsigned NPORT      = 4,
    parameter int unsigned N_PREAMBLE = 8,
    parameter int unsigned N_IFG      = 12,
    parameter int unsigned MAX_FRAME  = 1522
) (
    input  logic               clk_125m,
    input  logic               rst_n,
    input  logic [NPORT-1:0]   frame_ready,
    input  logic [NPORT-1:0]   rd_empty,
    input  logic [NPORT*8-1:0] rd_data,
    input  logic [NPORT-1:0]   rd_last,
    output logic [NPORT-1:0]   rd_en,
    output logic [NPORT-1:0]   grant,
    output logic               gmii_en,
    output logic [7:0]         gmii_dout,
    output logic               gmii_er,
    output logic [15:0]        err_cnt
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned TW = $clog2((N_PREAMBLE > N_IFG ? N_PREAMBLE : N_IFG) + 1);
    localparam int unsigned BW = $clog2(MAX_FRAME + 1);

    typedef enum logic [2:0] {StIdle, StPre, StData, StDrop, StIfg} state_e;

    state_e          state_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   ptr_q;
    logic [TW-1:0]   cnt_q;
    logic [BW-1:0]   byte_cnt_q;

    logic            arb_valid;
    logic [PW-1:0]   arb_idx;
    logic [NPORT-1:0] arb_grant;
    logic [7:0]      cur_data;
    logic            cur_empty;
    logic            cur_last;

    // Ports above the pointer take priority over those at or below it; lowest index wins
    // within each group, so the second loop overrides the first.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int i = int'(NPORT) - 1; i >= 0; i--) begin
            if (frame_ready[i] && (i <= int'(ptr_q))) begin
                arb_valid = 1'b1;
                arb_idx   = PW'(i);
            end
        end
        for (int i = int'(NPORT) - 1; i >= 0; i--) begin
            if (frame_ready[i] && (i > int'(ptr_q))) begin
                arb_valid = 1'b1;
                arb_idx   = PW'(i);
            end
        end
        arb_grant          = '0;
        arb_grant[arb_idx] = arb_valid;
    end

    always_comb begin
        cur_data  = 8'h00;
        cur_empty = 1'b1;
        cur_last  = 1'b0;
        for (int i = 0; i < int'(NPORT); i++) begin
            if (owner_q == PW'(i)) begin
                cur_data  = rd_data[i*8 +: 8];
                cur_empty = rd_empty[i];
                cur_last  = rd_last[i];
            end
        end
    end

    // Gated by rst_n so a reset cycle never pops a FIFO.
    always_comb begin
        rd_en = '0;
        if (rst_n && !cur_empty && (state_q == StData || state_q == StDrop)) begin
            rd_en = grant;
        end
    end

    always_ff @(posedge clk_125m) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            ptr_q      <= PW'(NPORT - 1);
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            grant      <= '0;
            gmii_en    <= 1'b0;
            gmii_dout  <= 8'h00;
            gmii_er    <= 1'b0;
            err_cnt    <= 16'h0000;
        end else begin
            gmii_en   <= 1'b0;
            gmii_dout <= 8'h00;
            gmii_er   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        state_q <= StPre;
                        cnt_q   <= '0;
                        grant   <= arb_grant;
                        owner_q <= arb_idx;
                        ptr_q   <= arb_idx;
                    end
                end
                StPre: begin
                    gmii_en <= 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == TW'(N_PREAMBLE - 1)) begin
                        gmii_dout  <= 8'hD5;
                        state_q    <= StData;
                        byte_cnt_q <= '0;
                    end else begin
                        gmii_dout <= 8'h55;
                    end
                end
                StData: begin
                    if (cur_empty || (byte_cnt_q == BW'(MAX_FRAME))) begin
                        // Single error cycle; an oversize byte is popped but not sent.
                        gmii_en <= 1'b1;
                        gmii_er <= 1'b1;
                        err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
                        cnt_q   <= '0;
                        state_q <= (!cur_empty && cur_last) ? StIfg : StDrop;
                    end else begin
                        gmii_en    <= 1'b1;
                        gmii_dout  <= cur_data;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (cur_last) begin
                            state_q <= StIfg;
                            cnt_q   <= '0;
                        end
                    end
                end
                StDrop: begin
                    if (!cur_empty && cur_last) begin
                        state_q <= StIfg;
                        cnt_q   <= '0;
                    end
                end
                StIfg: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == TW'(N_IFG - 1)) begin
                        if (arb_valid) begin
                            state_q <= StPre;
                            cnt_q   <= '0;
                            grant   <= arb_grant;
                            owner_q <= arb_idx;
                            ptr_q   <= arb_idx;
                        end else begin
                            state_q <= StIdle;
                            grant   <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: per-port FWFT FIFO models feed the DUT and a GMII
// monitor splits the output stream into frames that are checked against hand-set values.
module tb_gmii_tx_arbiter;

    localparam int NPORT = 4;
    localparam int DEPTH = 8192;
    localparam int LOGSZ = 4096;

    logic               clk_125m;
    logic               rst_n;
    logic [NPORT-1:0]   frame_ready;
    logic [NPORT-1:0]   rd_empty;
    logic [NPORT*8-1:0] rd_data;
    logic [NPORT-1:0]   rd_last;
    logic [NPORT-1:0]   rd_en;
    logic [NPORT-1:0]   grant;
    logic               gmii_en;
    logic [7:0]         gmii_dout;
    logic               gmii_er;
    logic [15:0]        err_cnt;

    gmii_tx_arbiter dut (
        .clk_125m    (clk_125m),
        .rst_n       (rst_n),
        .frame_ready (frame_ready),
        .rd_empty    (rd_empty),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .rd_en       (rd_en),
        .grant       (grant),
        .gmii_en     (gmii_en),
        .gmii_dout   (gmii_dout),
        .gmii_er     (gmii_er),
        .err_cnt     (err_cnt)
    );

    initial begin
        clk_125m = 1'b0;
        forever #4 clk_125m = ~clk_125m;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO models: bit 8 of each entry is the last-byte flag.
    logic [8:0]       mem [NPORT][DEPTH];
    int               rp [NPORT];
    int               wp [NPORT];
    int               nfr [NPORT];
    int               pops [NPORT];
    logic [NPORT-1:0] hold;
    logic [NPORT-1:0] en_s;

    // Monitor log.
    logic [7:0] fbytes [LOGSZ];
    int fr_owner [32];
    int fr_start [32];
    int fr_len [32];
    int fr_gap [32];
    int fr_err [32];
    int nfrm, nb, idle_run;
    bit in_frame;

    int bad_pre, bad_data, gmin, gmax, nerr;
    logic [31:0] owners;

    function automatic logic [7:0] pat(input int port, input int seq, input int k);
        return 8'(port * 37 + seq * 11 + k);
    endfunction

    function automatic int onehot_idx(input logic [NPORT-1:0] g);
        int r = 15;
        for (int i = 0; i < NPORT; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit fifos_idle();
        bit r = 1'b1;
        for (int i = 0; i < NPORT; i++) if (rp[i] != wp[i] || nfr[i] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NPORT; i++) begin
            rd_empty[i]        = (rp[i] == wp[i]) || hold[i];
            rd_data[i*8 +: 8]  = mem[i][rp[i]][7:0];
            rd_last[i]         = mem[i][rp[i]][8];
            frame_ready[i]     = (nfr[i] > 0);
        end
    endtask

    task automatic load_frame(input int port, input int seq, input int len);
        for (int k = 0; k < len; k++) begin
            mem[port][wp[port]] = {(k == len - 1), pat(port, seq, k)};
            wp[port]++;
        end
        nfr[port]++;
    endtask

    task automatic clear_log();
        nfrm = 0;
        nb = 0;
        idle_run = 0;
        in_frame = 1'b0;
        for (int i = 0; i < NPORT; i++) pops[i] = 0;
        for (int f = 0; f < 32; f++) begin
            fr_len[f] = 0;
            fr_err[f] = 0;
        end
    endtask

    // One clock: monitor at the falling edge, then FIFO pops and new inputs just after the
    // rising edge.
    task automatic tick();
        @(negedge clk_125m);
        if (gmii_en) begin
            if (!in_frame && nfrm < 32) begin
                in_frame       = 1'b1;
                fr_owner[nfrm] = onehot_idx(grant);
                fr_start[nfrm] = nb;
                fr_gap[nfrm]   = idle_run;
                fr_err[nfrm]   = 0;
            end
            if (nb < LOGSZ) begin
                fbytes[nb] = gmii_dout;
                nb++;
            end
            if (gmii_er && nfrm < 32) fr_err[nfrm]++;
        end else begin
            if (in_frame) begin
                fr_len[nfrm] = nb - fr_start[nfrm];
                nfrm++;
                in_frame = 1'b0;
                idle_run = 0;
            end
            idle_run++;
        end
        en_s = rd_en;
        @(posedge clk_125m);
        #1;
        for (int i = 0; i < NPORT; i++) begin
            if (en_s[i]) begin
                check_eq("pop_on_empty", 64'(rd_empty[i]), 64'd0);
                if (rp[i] != wp[i]) begin
                    if (mem[i][rp[i]][8]) nfr[i]--;
                    rp[i]++;
                    pops[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold  = '0;
        for (int i = 0; i < NPORT; i++) begin
            rp[i]  = 0;
            wp[i]  = 0;
            nfr[i] = 0;
        end
        drive();
        tick();
        tick();
        check_eq("rst_outputs", 64'({gmii_en, gmii_er, gmii_dout, grant, rd_en}), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        drive();
        clear_log();
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (grant == '0 && !in_frame && fifos_idle()) done = 1'b1;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic wait_pops(input int port, input int n, input int budget, input string tag);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (pops[port] >= n) done = 1'b1;
        end
        check_eq({tag, "_reached"}, 64'(done), 64'd1);
    endtask

    task automatic analyze();
        int seq [NPORT];
        int o, ndata;
        bad_pre  = 0;
        bad_data = 0;
        gmin     = 1000000;
        gmax     = -1;
        nerr     = 0;
        owners   = '0;
        for (int i = 0; i < NPORT; i++) seq[i] = 0;
        for (int f = 0; f < nfrm; f++) begin
            o      = fr_owner[f];
            owners = (owners << 4) | 32'(o & 15);
            for (int k = 0; k < 8; k++) begin
                if (fbytes[fr_start[f] + k] !== ((k == 7) ? 8'hD5 : 8'h55)) bad_pre++;
            end
            ndata = fr_len[f] - 8 - ((fr_err[f] > 0) ? 1 : 0);
            if (o < NPORT) begin
                for (int k = 0; k < ndata; k++) begin
                    if (fr_start[f] + 8 + k < LOGSZ &&
                        fbytes[fr_start[f] + 8 + k] !== pat(o, seq[o], k)) bad_data++;
                end
                seq[o]++;
            end
            if (f > 0) begin
                if (fr_gap[f] < gmin) gmin = fr_gap[f];
                if (fr_gap[f] > gmax) gmax = fr_gap[f];
            end
            nerr += fr_err[f];
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        hold        = '0;
        frame_ready = '0;
        rd_empty    = '1;
        rd_data     = '0;
        rd_last     = '0;
        clear_log();

        // 1: single 60-byte frame from port 0.
        do_reset();
        load_frame(0, 0, 60);
        drive();
        run_until_quiet(200, "t1");
        analyze();
        check_eq("t1_nframes", 64'(nfrm), 64'd1);
        check_eq("t1_len", 64'(fr_len[0]), 64'd68);
        check_eq("t1_owner", 64'(owners), 64'h0);
        check_eq("t1_preamble", 64'(bad_pre), 64'd0);
        check_eq("t1_data", 64'(bad_data), 64'd0);
        check_eq("t1_er", 64'(nerr), 64'd0);
        check_eq("t1_pops", 64'(pops[0]), 64'd60);
        check_eq("t1_idle_en", 64'(gmii_en), 64'd0);

        // 2: all four ports with two frames each.
        do_reset();
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPORT; p++) load_frame(p, s, 20 + p * 3 + s);
        drive();
        run_until_quiet(800, "t2");
        analyze();
        check_eq("t2_nframes", 64'(nfrm), 64'd8);
        check_eq("t2_order", 64'(owners), 64'h01230123);
        check_eq("t2_gap_min", 64'(gmin), 64'd12);
        check_eq("t2_gap_max", 64'(gmax), 64'd12);
        check_eq("t2_preamble", 64'(bad_pre), 64'd0);
        check_eq("t2_data", 64'(bad_data), 64'd0);

        // 3: port 2 underruns after 20 bytes for 5 cycles; port 3 follows cleanly.
        do_reset();
        load_frame(2, 0, 64);
        load_frame(3, 0, 30);
        drive();
        wait_pops(2, 20, 100, "t3");
        hold[2] = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) tick();
        hold[2] = 1'b0;
        drive();
        run_until_quiet(400, "t3");
        analyze();
        check_eq("t3_nframes", 64'(nfrm), 64'd2);
        check_eq("t3_order", 64'(owners), 64'h23);
        check_eq("t3_len_err", 64'(fr_len[0]), 64'd29);
        check_eq("t3_err_cycles", 64'(fr_err[0]), 64'd1);
        check_eq("t3_err_byte", 64'(fbytes[fr_start[0] + 28]), 64'h00);
        check_eq("t3_len_next", 64'(fr_len[1]), 64'd38);
        check_eq("t3_er_next", 64'(fr_err[1]), 64'd0);
        check_eq("t3_data", 64'(bad_data), 64'd0);
        check_eq("t3_drained", 64'(pops[2]), 64'd64);
        check_eq("t3_err_cnt", 64'(err_cnt), 64'd1);

        // 4: port 1 frame of 1600 bytes is cut at 1522.
        do_reset();
        load_frame(1, 0, 1600);
        drive();
        run_until_quiet(2000, "t4");
        analyze();
        check_eq("t4_nframes", 64'(nfrm), 64'd1);
        check_eq("t4_len", 64'(fr_len[0]), 64'd1531);
        check_eq("t4_err_cycles", 64'(fr_err[0]), 64'd1);
        check_eq("t4_err_byte", 64'(fbytes[fr_start[0] + 1530]), 64'h00);
        check_eq("t4_data", 64'(bad_data), 64'd0);
        check_eq("t4_drained", 64'(pops[1]), 64'd1600);
        check_eq("t4_err_cnt", 64'(err_cnt), 64'd1);

        // 5: reset mid-frame (err_cnt still 1, pointer on port 1 from the previous frame).
        clear_log();
        load_frame(1, 0, 40);
        drive();
        wait_pops(1, 10, 100, "t5");
        rst_n  = 1'b0;
        rp[1]  = wp[1];
        nfr[1] = 0;
        load_frame(0, 0, 10);
        load_frame(2, 0, 10);
        drive();
        tick();
        check_eq("t5_rst_en", 64'(gmii_en), 64'd0);
        check_eq("t5_rst_grant", 64'(grant), 64'd0);
        check_eq("t5_rst_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        drive();
        clear_log();
        run_until_quiet(300, "t5");
        analyze();
        check_eq("t5_order", 64'(owners), 64'h02);
        check_eq("t5_nframes", 64'(nfrm), 64'd2);
        check_eq("t5_gap", 64'(gmin), 64'd12);
        check_eq("t5_data", 64'(bad_data), 64'd0);

        // 6: only port 3 ready, three frames back to back.
        do_reset();
        for (int s = 0; s < 3; s++) load_frame(3, s, 16);
        drive();
        run_until_quiet(400, "t6");
        analyze();
        check_eq("t6_order", 64'(owners), 64'h333);
        check_eq("t6_gap_min", 64'(gmin), 64'd12);
        check_eq("t6_gap_max", 64'(gmax), 64'd12);
        check_eq("t6_data", 64'(bad_data), 64'd0);
        check_eq("t6_er", 64'(nerr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
